// File: rtl/sdram_pkg.sv
// Shared SDRAM command codes and arbiter state encoding, used by the arbiter
// and by the init/refresh/write/read engines.
package sdram_pkg;

   // {CKE, CS_N, RAS_N, CAS_N, WE_N}
   localparam logic [4:0] CMD_NOP   = 5'b10111;
   localparam logic [4:0] CMD_PREC  = 5'b10010;
   localparam logic [4:0] CMD_AREF  = 5'b10001;
   localparam logic [4:0] CMD_ACT   = 5'b10011;
   localparam logic [4:0] CMD_WRITE = 5'b10100;
   localparam logic [4:0] CMD_READ  = 5'b10101;
   localparam logic [4:0] CMD_MRS   = 5'b10000;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Combinational select of the granted engine's command/address/bank onto the
// SDRAM bus, keyed only by the registered arbiter state.
module sdram_cmd_mux
   import sdram_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int BANK_W = 2,
   parameter int CMD_W  = 5
) (
   input  arb_state_t        state,
   input  logic [CMD_W-1:0]  init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [CMD_W-1:0]  aref_cmd,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic [CMD_W-1:0]  wr_cmd,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [CMD_W-1:0]  rd_cmd,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [BANK_W-1:0] rd_bank,
   output logic [CMD_W-1:0]  cmd,
   output logic [ADDR_W-1:0] addr,
   output logic [BANK_W-1:0] bank
);

   always_comb begin
      cmd  = CMD_W'(CMD_NOP);
      addr = '0;
      bank = '0;
      case (state)
         ST_INIT: begin
            cmd  = init_cmd;
            addr = init_addr;
         end
         ST_AREF: begin
            cmd  = aref_cmd;
            addr = aref_addr;
         end
         ST_WRITE: begin
            cmd  = wr_cmd;
            addr = wr_addr;
            bank = wr_bank;
         end
         ST_READ: begin
            cmd  = rd_cmd;
            addr = rd_addr;
            bank = rd_bank;
         end
         default: begin
            cmd  = CMD_W'(CMD_NOP);
            addr = '0;
            bank = '0;
         end
      endcase
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Fixed-priority grant FSM (refresh > write > read) for the SDRAM engines,
// with per-grant ack timeout and the shared SDRAM bus mux.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_INIT  | init engine owns the bus, waiting for flag_init
//   ST_IDLE  | bus idles with NOP, arbitrating pending requests
//   ST_AREF  | refresh engine granted until aref_ack or timeout
//   ST_WRITE | write engine granted until wr_ack or timeout
//   ST_READ  | read engine granted until rd_ack or timeout
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int BANK_W      = 2,
   parameter int CMD_W       = 5,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              S_CLK,
   input  logic              RST,
   input  logic              flag_init,
   input  logic [CMD_W-1:0]  init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              aref_req,
   input  logic              aref_ack,
   output logic              aref_en,
   input  logic [CMD_W-1:0]  aref_cmd,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              wr_req,
   input  logic              wr_ack,
   output logic              wr_en,
   input  logic [CMD_W-1:0]  wr_cmd,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic              rd_req,
   input  logic              rd_ack,
   output logic              rd_en,
   input  logic [CMD_W-1:0]  rd_cmd,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [BANK_W-1:0] rd_bank,
   output logic              aref_pending,
   output logic              arb_err,
   output logic [CMD_W-1:0]  sdram_cmd,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [BANK_W-1:0] sdram_bank
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   arb_state_t       state;
   logic [CNT_W-1:0] tmo_cnt;
   logic             grant_ack;

   always_comb begin
      grant_ack = 1'b0;
      case (state)
         ST_AREF:  grant_ack = aref_ack;
         ST_WRITE: grant_ack = wr_ack;
         ST_READ:  grant_ack = rd_ack;
         default:  grant_ack = 1'b0;
      endcase
   end

   always_ff @(posedge S_CLK or posedge RST) begin
      if (RST) begin
         state   <= ST_INIT;
         aref_en <= 1'b0;
         wr_en   <= 1'b0;
         rd_en   <= 1'b0;
         arb_err <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         arb_err <= 1'b0;
         // Losing flag_init outranks everything, including a pending ack.
         if (state != ST_INIT && !flag_init) begin
            state   <= ST_INIT;
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            tmo_cnt <= '0;
         end else begin
            case (state)
               ST_INIT: begin
                  tmo_cnt <= '0;
                  if (flag_init) state <= ST_IDLE;
               end
               ST_IDLE: begin
                  tmo_cnt <= '0;
                  if (aref_req) begin
                     state   <= ST_AREF;
                     aref_en <= 1'b1;
                  end else if (wr_req) begin
                     state <= ST_WRITE;
                     wr_en <= 1'b1;
                  end else if (rd_req) begin
                     state <= ST_READ;
                     rd_en <= 1'b1;
                  end
               end
               ST_AREF, ST_WRITE, ST_READ: begin
                  if (grant_ack || tmo_cnt == TMO_LAST) begin
                     state   <= ST_IDLE;
                     aref_en <= 1'b0;
                     wr_en   <= 1'b0;
                     rd_en   <= 1'b0;
                     tmo_cnt <= '0;
                     arb_err <= ~grant_ack;
                  end else begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end
               end
               default: begin
                  state   <= ST_INIT;
                  aref_en <= 1'b0;
                  wr_en   <= 1'b0;
                  rd_en   <= 1'b0;
                  tmo_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign aref_pending = aref_req & (state == ST_WRITE || state == ST_READ);

   sdram_cmd_mux #(
      .ADDR_W (ADDR_W),
      .BANK_W (BANK_W),
      .CMD_W  (CMD_W)
   ) u_cmd_mux (
      .state     (state),
      .init_cmd  (init_cmd),
      .init_addr (init_addr),
      .aref_cmd  (aref_cmd),
      .aref_addr (aref_addr),
      .wr_cmd    (wr_cmd),
      .wr_addr   (wr_addr),
      .wr_bank   (wr_bank),
      .rd_cmd    (rd_cmd),
      .rd_addr   (rd_addr),
      .rd_bank   (rd_bank),
      .cmd       (sdram_cmd),
      .addr      (sdram_addr),
      .bank      (sdram_bank)
   );

endmodule
